if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0: first fetch address after reset.
REQ-002 Parameter FBUF_DEPTH, default 2, fixed at 2: fetch buffer entries.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 o_imem_req  out  1  instruction memory request.
REQ-006 o_imem_addr  out  64  fetch address, word aligned.
REQ-007 i_imem_gnt  in  1  request accepted this cycle.
REQ-008 i_imem_rvalid  in  1  response data valid.
REQ-009 i_imem_rdata  in  32  returned instruction word.
REQ-010 i_ex_redirect  in  1  taken branch/jump; flush and refetch.
REQ-011 i_ex_target  in  64  redirect target address.
REQ-012 i_id_ready  in  1  decode accepts the head instruction.
REQ-013 o_if_valid  out  1  o_if_instr/o_if_pc hold a valid entry.
REQ-014 o_if_instr  out  32  instruction to decode.
REQ-015 o_if_pc  out  64  PC of o_if_instr.
REQ-016 o_if_fault  out  1  fetch halted on a misaligned target.

Function
REQ-017 State: fetch_pc (64b), req_pc (64b), pending (1b), kill (1b), 2-entry FIFO of {instr, pc} with count 0..2, FSM {RUN, FAULT}.
REQ-018 o_imem_req = (state==RUN) && !pending && (count+pending < 2) && !i_ex_redirect; o_imem_addr = fetch_pc.
REQ-019 Once asserted, o_imem_req and o_imem_addr hold stable until i_imem_gnt; a redirect is the only exception.
REQ-020 Handshake: on o_imem_req && i_imem_gnt, req_pc <= fetch_pc, fetch_pc <= fetch_pc+4 (64-bit wrap), pending <= 1.
REQ-021 Single outstanding request; i_imem_rvalid is honoured only while pending==1 and is otherwise ignored.
REQ-022 On i_imem_rvalid with pending: pending <= 0; if kill, drop the data and set kill <= 0; else push {i_imem_rdata, req_pc}.
REQ-023 Latency: a push at edge N drives o_if_valid=1 in cycle N+1; there is no rdata-to-output bypass.
REQ-024 o_if_valid = (count != 0); o_if_instr/o_if_pc are the FIFO head; a pop occurs when o_if_valid && i_id_ready.
REQ-025 A simultaneous push and pop leaves count unchanged and preserves order.
REQ-026 The REQ-018 gating makes overflow impossible; a push when count==2 is a design error (assertion).
REQ-027 Redirect has highest priority: FIFO flushed (count <= 0), and any pop or push in that cycle is discarded.
REQ-028 Redirect with aligned target (i_ex_target[1:0]==0): fetch_pc <= i_ex_target, state <= RUN.
REQ-029 Redirect with pending && !i_imem_rvalid: kill <= 1. With pending && i_imem_rvalid: response dropped, pending <= 0, kill <= 0.
REQ-030 A grant in the redirect cycle is impossible, because o_imem_req is forced low (REQ-018).
REQ-031 Redirect with misaligned target: state <= FAIL-SAFE FAULT; o_if_fault=1; no requests; the pending response is killed per REQ-029.
REQ-032 FAULT exits only on an aligned redirect (to RUN) or on reset.
REQ-033 o_if_valid is 0 throughout FAULT.

Reset
REQ-034 While rst=1: fetch_pc=RESET_PC, req_pc=0, pending=0, kill=0, count=0, state=RUN.
REQ-035 While rst=1, outputs are o_imem_req=0, o_if_valid=0, o_if_fault=0, o_if_instr=0, o_if_pc=0.
REQ-036 The first request is issued in the first cycle after rst deasserts.
REQ-037 Reset mid-transaction abandons any outstanding response; rvalid arriving after reset with pending=0 is ignored.

Verification
REQ-038 Streaming: RESET_PC=0x1000, gnt and rvalid each one cycle after request, i_id_ready=1 -> decode sees PCs 0x1000, 0x1004, 0x1008 in order, each one cycle after its rvalid.
REQ-039 Backpressure: i_id_ready=0 -> FIFO fills to 2 (0x1000, 0x1004), o_imem_req drops to 0.
REQ-039a Backpressure, continued: i_id_ready=1 then pops both in order, and fetching resumes at 0x1008.
REQ-040 Redirect with outstanding response: request 0x1008 granted, redirect to 0x2000 before rvalid -> the 0x1008 data is dropped.
REQ-040a Redirect, continued: the next request goes to 0x2000 after that rvalid, and o_if_pc shows 0x2000 next.
REQ-041 Redirect coincident with rvalid and pop, count=1 -> FIFO empties, the response is dropped, and the next request is 0x3000 (target) in the following cycle.
REQ-042 Misaligned redirect to 0x4002 -> o_if_fault=1, o_imem_req=0 for 10 cycles.
REQ-042a Fault recovery: a later redirect to 0x4000 clears the fault and fetches 0x4000.
REQ-043 Reset asserted one cycle after a grant, then rvalid during reset -> after release, the first fetch is RESET_PC and no stale entry appears.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch with one outstanding imem request and a 2-entry fetch buffer
// Ports: clk/rst; imem request/grant/response; EX redirect; decode head (valid/instr/pc/ready); fault flag.
module if_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_imem_req,
  output logic [63:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_ex_redirect,
  input  logic [63:0] i_ex_target,
  input  logic        i_id_ready,
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  output logic [63:0] o_if_pc,
  output logic        o_if_fault
);
  typedef enum logic {RUN, FAULT} state_e;
  state_e      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic        pending_q, pending_d, kill_q, kill_d;
  logic [1:0]  count_q, count_d;
  logic        rd_q, wr_q;
  logic [31:0] instr_q [2];
  logic [63:0] pc_q [2];
  logic        grant, rsp, push, pop, aligned;
  // pending is counted against buffer space so a granted response always has a slot
  assign o_imem_req  = !rst && state_q == RUN && !pending_q && !i_ex_redirect &&
                       (({1'b0, count_q} + {2'b0, pending_q}) < 3'(FBUF_DEPTH));
  assign o_imem_addr = fetch_pc_q;
  assign o_if_valid  = !rst && state_q == RUN && count_q != 2'd0;
  assign o_if_instr  = o_if_valid ? instr_q[rd_q] : 32'h0;
  assign o_if_pc     = o_if_valid ? pc_q[rd_q] : 64'h0;
  assign o_if_fault  = !rst && state_q == FAULT;
  assign grant   = o_imem_req && i_imem_gnt;
  assign rsp     = pending_q && i_imem_rvalid;
  assign push    = rsp && !kill_q && !i_ex_redirect;
  assign pop     = o_if_valid && i_id_ready && !i_ex_redirect;
  assign aligned = i_ex_target[1:0] == 2'b00;
  always_comb begin
    state_d    = i_ex_redirect ? (aligned ? RUN : FAULT) : state_q;
    fetch_pc_d = (i_ex_redirect && aligned) ? i_ex_target : grant ? fetch_pc_q + 64'd4 : fetch_pc_q;
    req_pc_d   = grant ? fetch_pc_q : req_pc_q;
    pending_d  = grant || (pending_q && !i_imem_rvalid);
    // a redirect with a response still in flight marks it for discard on arrival
    kill_d     = i_ex_redirect ? (pending_q && !i_imem_rvalid) : (kill_q && !rsp);
    count_d    = i_ex_redirect ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 64'h0;
      pending_q  <= 1'b0;
      kill_q     <= 1'b0;
      count_q    <= 2'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      pending_q  <= pending_d;
      kill_q     <= kill_d;
      count_q    <= count_d;
      rd_q       <= i_ex_redirect ? 1'b0 : rd_q ^ pop;
      wr_q       <= i_ex_redirect ? 1'b0 : wr_q ^ push;
      if (push) begin
        instr_q[wr_q] <= i_imem_rdata;
        pc_q[wr_q]    <= req_pc_q;
      end
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && count_q == 2'd2));
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: table, directed and randomized checks of if_stage against a queue-based model
module tb_if_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req, gnt = 1'b0, rv = 1'b0, redir = 1'b0, rdy = 1'b0;
  logic        val, fault;
  logic [63:0] addr, tgt = 64'h0, pc;
  logic [31:0] rdata = 32'h0, instr;
  int          n_chk = 0, n_pass = 0;

  if_stage #(.RESET_PC(64'h1000)) dut (
    .clk(clk), .rst(rst), .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt),
    .i_imem_rvalid(rv), .i_imem_rdata(rdata), .i_ex_redirect(redir), .i_ex_target(tgt),
    .i_id_ready(rdy), .o_if_valid(val), .o_if_instr(instr), .o_if_pc(pc), .o_if_fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cyc(input logic r, input logic g, input logic v, input logic [31:0] d,
                     input logic rd, input logic [63:0] t, input logic y);
    @(negedge clk);
    rst = r; gnt = g; rv = v; rdata = d; redir = rd; tgt = t; rdy = y;
    #1;
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic r, g, v; logic [31:0] d; logic y;
    logic e_req; logic [63:0] e_addr; logic e_val; logic [63:0] e_pc; logic [31:0] e_ins;
  } vec_t;
  vec_t tbl[11];

  typedef struct { logic [31:0] i; logic [63:0] p; } ent_t;
  ent_t        q[$];
  logic [63:0] m_fpc, m_rpc;
  bit          m_pend, m_kill, m_fault, e_req, e_val, do_push;

  initial begin
    // streaming: grant one cycle after request, rvalid one cycle after grant, decode always ready
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 64'h1000, 1'b0, 64'h0,    32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 64'h1000, 1'b0, 64'h0,    32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 64'h1000, 1'b0, 64'h0,    32'h0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'hA0A0A0A0, 1'b1, 1'b0, 64'h1004, 1'b0, 64'h0,    32'h0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 64'h1004, 1'b1, 64'h1000, 32'hA0A0A0A0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 64'h1004, 1'b0, 64'h0,    32'h0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'hA1A1A1A1, 1'b1, 1'b0, 64'h1008, 1'b0, 64'h0,    32'h0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 64'h1008, 1'b1, 64'h1004, 32'hA1A1A1A1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 64'h1008, 1'b0, 64'h0,    32'h0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'hA2A2A2A2, 1'b1, 1'b0, 64'h100C, 1'b0, 64'h0,    32'h0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 64'h100C, 1'b1, 64'h1008, 32'hA2A2A2A2};
    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].g, tbl[i].v, tbl[i].d, 0, 0, tbl[i].y);
      chk($sformatf("tbl%0d req", i), 64'(req), 64'(tbl[i].e_req));
      chk($sformatf("tbl%0d addr", i), addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d valid", i), 64'(val), 64'(tbl[i].e_val));
      chk($sformatf("tbl%0d fault", i), 64'(fault), 64'h0);
      if (tbl[i].e_val || tbl[i].r) begin
        chk($sformatf("tbl%0d pc", i), pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d instr", i), 64'(instr), 64'(tbl[i].e_ins));
      end
    end

    // backpressure: buffer fills with 0x1000/0x1004, request drops, then drains and resumes at 0x1008
    do_reset();
    cyc(0, 1, 1, 32'h0, 0, 0, 0);        chk("bp c1 req", 64'(req), 1); chk("bp c1 addr", addr, 64'h1000);
    cyc(0, 1, 1, 32'h11111111, 0, 0, 0); chk("bp c2 req", 64'(req), 0);
    cyc(0, 1, 1, 32'h0, 0, 0, 0);        chk("bp c3 addr", addr, 64'h1004); chk("bp c3 req", 64'(req), 1);
    cyc(0, 1, 1, 32'h22222222, 0, 0, 0); chk("bp c4 req", 64'(req), 0);
    cyc(0, 1, 1, 32'h0, 0, 0, 0);        chk("bp full req", 64'(req), 0); chk("bp full pc", pc, 64'h1000);
    cyc(0, 1, 0, 32'h0, 0, 0, 1);        chk("bp pop1 pc", pc, 64'h1000); chk("bp pop1 instr", 64'(instr), 64'h11111111);
    chk("bp pop1 req", 64'(req), 0);
    cyc(0, 1, 0, 32'h0, 0, 0, 1);        chk("bp pop2 pc", pc, 64'h1004); chk("bp pop2 instr", 64'(instr), 64'h22222222);
    chk("bp resume req", 64'(req), 1);   chk("bp resume addr", addr, 64'h1008);

    // redirect while 0x1008 is outstanding: its data is dropped, fetch resumes at 0x2000
    do_reset();
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, 0, 32'h0, 0, 0, 1);
      cyc(0, 0, 1, 32'h5A5A5A5A, 0, 0, 1);
    end
    cyc(0, 1, 0, 32'h0, 0, 0, 1);           chk("rd grant addr", addr, 64'h1008); chk("rd grant req", 64'(req), 1);
    cyc(0, 0, 0, 32'h0, 1, 64'h2000, 1);    chk("rd redir req", 64'(req), 0);
    cyc(0, 0, 0, 32'h0, 0, 0, 1);           chk("rd wait req", 64'(req), 0); chk("rd wait valid", 64'(val), 0);
    cyc(0, 0, 1, 32'hDEADDEAD, 0, 0, 1);    chk("rd drop req", 64'(req), 0);
    cyc(0, 1, 0, 32'h0, 0, 0, 1);           chk("rd new req", 64'(req), 1); chk("rd new addr", addr, 64'h2000);
    chk("rd no stale", 64'(val), 0);
    cyc(0, 0, 1, 32'hBEEFBEEF, 0, 0, 1);    chk("rd rsp valid", 64'(val), 0);
    cyc(0, 0, 0, 32'h0, 0, 0, 1);           chk("rd head pc", pc, 64'h2000); chk("rd head instr", 64'(instr), 64'hBEEFBEEF);

    // redirect coinciding with rvalid and a pop while one entry is buffered
    do_reset();
    cyc(0, 1, 0, 32'h0, 0, 0, 0);
    cyc(0, 0, 1, 32'h33333333, 0, 0, 0);
    cyc(0, 1, 0, 32'h0, 0, 0, 0);           chk("co grant addr", addr, 64'h1004);
    cyc(0, 0, 1, 32'h77777777, 1, 64'h3000, 1);
    chk("co redir req", 64'(req), 0);       chk("co redir valid", 64'(val), 1); chk("co redir pc", pc, 64'h1000);
    cyc(0, 0, 0, 32'h0, 0, 0, 1);
    chk("co next req", 64'(req), 1);        chk("co next addr", addr, 64'h3000); chk("co empty", 64'(val), 0);

    // misaligned redirect halts fetch until an aligned redirect
    cyc(0, 0, 0, 32'h0, 1, 64'h4002, 1);    chk("mis redir req", 64'(req), 0);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, 1, 32'h99999999, 0, 0, 1);
      chk($sformatf("flt%0d fault", k), 64'(fault), 1);
      chk($sformatf("flt%0d req", k), 64'(req), 0);
      chk($sformatf("flt%0d valid", k), 64'(val), 0);
    end
    cyc(0, 0, 0, 32'h0, 1, 64'h4000, 1);    chk("rec redir req", 64'(req), 0);
    cyc(0, 1, 0, 32'h0, 0, 0, 1);
    chk("rec fault", 64'(fault), 0);        chk("rec req", 64'(req), 1); chk("rec addr", addr, 64'h4000);
    cyc(0, 0, 1, 32'h44444444, 0, 0, 1);
    cyc(0, 0, 0, 32'h0, 0, 0, 1);           chk("rec pc", pc, 64'h4000); chk("rec instr", 64'(instr), 64'h44444444);

    // reset one cycle after a grant, response arrives during and after reset
    do_reset();
    cyc(0, 1, 0, 32'h0, 0, 0, 1);           chk("rst grant addr", addr, 64'h1000);
    cyc(1, 0, 0, 32'h0, 0, 0, 1);           chk("rst1 req", 64'(req), 0); chk("rst1 valid", 64'(val), 0);
    chk("rst1 pc", pc, 64'h0);              chk("rst1 instr", 64'(instr), 64'h0);
    cyc(1, 0, 1, 32'hBADBAD00, 0, 0, 1);    chk("rst2 req", 64'(req), 0); chk("rst2 valid", 64'(val), 0);
    cyc(0, 0, 1, 32'hBADBAD01, 0, 0, 1);    chk("post req", 64'(req), 1); chk("post addr", addr, 64'h1000);
    chk("post valid", 64'(val), 0);
    cyc(0, 0, 0, 32'h0, 0, 0, 1);           chk("post2 valid", 64'(val), 0); chk("post2 addr", addr, 64'h1000);

    // randomized run against the queue model
    m_fpc = 64'h1000; m_rpc = 0; m_pend = 0; m_kill = 0; m_fault = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      @(negedge clk);
      rst   = (i == 0) || ($urandom_range(199) == 0);
      redir = $urandom_range(m_fault ? 5 : 29) == 0;
      r     = $urandom_range(9);
      tgt   = r == 0 ? {$urandom, $urandom} : r == 1 ? 64'hFFFF_FFFF_FFFF_FFF8 :
              r == 2 ? ({$urandom, $urandom} | 64'h1) : ({32'h0, $urandom} & ~64'h3);
      gnt   = 1'($urandom_range(1));
      rv    = m_pend ? 1'($urandom_range(1)) : ($urandom_range(7) == 0);
      rdata = $urandom;
      rdy   = $urandom_range(3) != 0;
      #1;
      e_req = !rst && !m_fault && !m_pend && q.size() < 2 && !redir;
      e_val = !rst && !m_fault && q.size() != 0;
      chk("rnd req", 64'(req), 64'(e_req));
      chk("rnd valid", 64'(val), 64'(e_val));
      chk("rnd fault", 64'(fault), 64'(!rst && m_fault));
      if (e_req) chk("rnd addr", addr, m_fpc);
      if (e_val) begin
        chk("rnd pc", pc, q[0].p);
        chk("rnd instr", 64'(instr), 64'(q[0].i));
      end
      if (rst) begin
        q.delete(); m_fpc = 64'h1000; m_rpc = 0; m_pend = 0; m_kill = 0; m_fault = 0;
      end else if (redir) begin
        q.delete();
        m_kill = m_pend && !rv;
        if (m_pend && rv) m_pend = 0;
        m_fault = tgt[1:0] != 2'b00;
        if (!m_fault) m_fpc = tgt;
      end else begin
        do_push = m_pend && rv && !m_kill;
        if (m_pend && rv) begin m_pend = 0; m_kill = 0; end
        if (e_val && rdy) void'(q.pop_front());
        if (do_push) q.push_back('{i: rdata, p: m_rpc});
        if (e_req && gnt) begin m_rpc = m_fpc; m_fpc = m_fpc + 64'd4; m_pend = 1; end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
